// File: rtl/tr_mon_pkg.sv
// Shared types and constants for the riscv-tests result monitor.
package tr_mon_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } ch_state_e;

  localparam int unsigned MODE_PC     = 0;
  localparam int unsigned MODE_TOHOST = 1;

  localparam int unsigned TESTNUM_W  = 8;
  localparam int unsigned HOLD_CNT_W = 4;

endpackage

// File: rtl/tr_mon_ch.sv
// One monitored channel: completion detection FSM, hold filter and sticky verdict.
module tr_mon_ch
  import tr_mon_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     MODE        = MODE_PC,
  parameter logic [XLEN-1:0] DONE_PC     = 'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
  parameter int unsigned     HOLD        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 freeze,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      gp,
  input  logic                 st_valid,
  input  logic [XLEN-1:0]      st_addr,
  input  logic [XLEN-1:0]      st_data,
  output logic                 done,
  output logic                 pass,
  output logic [TESTNUM_W-1:0] testnum,
  output logic                 done_set_c
);

  localparam bit                    IS_TOHOST = (MODE == MODE_TOHOST);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM  = HOLD_CNT_W'(HOLD);
  localparam logic [HOLD_CNT_W-1:0] CNT_ONE   = HOLD_CNT_W'(1);

  ch_state_e             state, state_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt, hold_nxt;
  logic                  pc_hit, tohost_hit, step;
  logic [XLEN-1:0]       verdict_src;
  logic                  src_pass;

  assign pc_hit      = (pc == DONE_PC);
  assign tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
  assign step        = en && !freeze;
  // Verdict word is gp at the pc-match edge or the tohost store data.
  assign verdict_src = IS_TOHOST ? st_data : gp;
  assign src_pass    = (verdict_src == XLEN'(1));

  // Next-state and hold-counter logic; a frozen or disabled channel holds.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    done_set_c = 1'b0;
    if (step) begin
      case (state)
        ST_RUN: begin
          if (IS_TOHOST) begin
            if (tohost_hit) begin
              state_nxt  = ST_DONE;
              done_set_c = 1'b1;
            end
          end else if (pc_hit) begin
            hold_nxt = CNT_ONE;
            if (HOLD_LIM == CNT_ONE) begin
              state_nxt  = ST_DONE;
              done_set_c = 1'b1;
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (pc_hit) begin
            hold_nxt = hold_cnt + CNT_ONE;
            if (hold_nxt == HOLD_LIM) begin
              state_nxt  = ST_DONE;
              done_set_c = 1'b1;
            end
          end else begin
            state_nxt = ST_RUN;
            hold_nxt  = '0;
          end
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_RUN;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  // State, counter and sticky verdict registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      hold_cnt <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      testnum  <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (done_set_c) begin
        done    <= 1'b1;
        pass    <= src_pass;
        testnum <= src_pass ? '0 : verdict_src[TESTNUM_W:1];
      end
    end
  end

endmodule

// File: rtl/test_result_monitor.sv
// Multi-channel pass/fail monitor with watchdog, cycle counter and global status.
module test_result_monitor
  import tr_mon_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NCH         = 1,
  parameter int unsigned     MODE        = MODE_PC,
  parameter logic [XLEN-1:0] DONE_PC     = 'h44,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
  parameter int unsigned     HOLD        = 2,
  parameter int unsigned     TIMEOUT     = 6000,
  parameter int unsigned     CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NCH*XLEN-1:0]      pc,
  input  logic [NCH*XLEN-1:0]      gp,
  input  logic [NCH-1:0]           st_valid,
  input  logic [NCH*XLEN-1:0]      st_addr,
  input  logic [NCH*XLEN-1:0]      st_data,
  output logic [NCH-1:0]           ch_done,
  output logic [NCH-1:0]           ch_pass,
  output logic [NCH*TESTNUM_W-1:0] ch_testnum,
  output logic                     all_done,
  output logic                     all_pass,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycles
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NCH-1:0] ch_set_c;
  logic           expire_c;
  logic           timeout_nxt_c;

  // One FSM per channel; channels freeze once the watchdog has fired.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tr_mon_ch #(
      .XLEN       (XLEN),
      .MODE       (MODE),
      .DONE_PC    (DONE_PC),
      .TOHOST_ADDR(TOHOST_ADDR),
      .HOLD       (HOLD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .freeze    (timeout),
      .pc        (pc[i*XLEN +: XLEN]),
      .gp        (gp[i*XLEN +: XLEN]),
      .st_valid  (st_valid[i]),
      .st_addr   (st_addr[i*XLEN +: XLEN]),
      .st_data   (st_data[i*XLEN +: XLEN]),
      .done      (ch_done[i]),
      .pass      (ch_pass[i]),
      .testnum   (ch_testnum[i*TESTNUM_W +: TESTNUM_W]),
      .done_set_c(ch_set_c[i])
    );
  end

  // Expiry loses to a channel that completes the set on the same edge.
  assign expire_c      = en && !timeout && (cycles == WD_LAST) && !(&(ch_done | ch_set_c));
  assign timeout_nxt_c = timeout | expire_c;

  // Saturating cycle counter, sticky watchdog and registered global status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles   <= '0;
      timeout  <= 1'b0;
      all_done <= 1'b0;
      all_pass <= 1'b0;
    end else if (en) begin
      if (cycles != CNT_MAX) begin
        cycles <= cycles + CNT_W'(1);
      end
      timeout  <= timeout_nxt_c;
      all_done <= (&ch_done) | timeout_nxt_c;
      all_pass <= (&ch_done) & (&ch_pass) & ~timeout_nxt_c;
    end
  end

endmodule

// File: tb/tb_test_result_monitor.sv
// Directed bench for test_result_monitor: pc-match, tohost and watchdog configurations.
module tb_test_result_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Two-channel pc-match monitor, HOLD=2.
  logic        a_en = 1'b0;
  logic [63:0] a_pc = '0, a_gp = '0, a_sa = '0, a_sd = '0;
  logic [1:0]  a_sv = '0;
  logic [1:0]  a_ch_done, a_ch_pass;
  logic [15:0] a_ch_testnum;
  logic        a_all_done, a_all_pass, a_timeout;
  logic [15:0] a_cycles;

  // Single-channel tohost monitor.
  logic        b_en = 1'b0;
  logic [31:0] b_pc = '0, b_gp = '0, b_sa = '0, b_sd = '0;
  logic        b_sv = 1'b0;
  logic        b_ch_done, b_ch_pass;
  logic [7:0]  b_ch_testnum;
  logic        b_all_done, b_all_pass, b_timeout;
  logic [15:0] b_cycles;

  // Single-channel pc-match monitor, HOLD=1, short watchdog.
  logic        c_en = 1'b0;
  logic [31:0] c_pc = '0, c_gp = '0, c_sa = '0, c_sd = '0;
  logic        c_sv = 1'b0;
  logic        c_ch_done, c_ch_pass;
  logic [7:0]  c_ch_testnum;
  logic        c_all_done, c_all_pass, c_timeout;
  logic [7:0]  c_cycles;

  test_result_monitor #(.NCH(2), .MODE(0), .HOLD(2)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .pc(a_pc), .gp(a_gp), .st_valid(a_sv),
    .st_addr(a_sa), .st_data(a_sd), .ch_done(a_ch_done), .ch_pass(a_ch_pass),
    .ch_testnum(a_ch_testnum), .all_done(a_all_done), .all_pass(a_all_pass),
    .timeout(a_timeout), .cycles(a_cycles)
  );

  test_result_monitor #(.NCH(1), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .pc(b_pc), .gp(b_gp), .st_valid(b_sv),
    .st_addr(b_sa), .st_data(b_sd), .ch_done(b_ch_done), .ch_pass(b_ch_pass),
    .ch_testnum(b_ch_testnum), .all_done(b_all_done), .all_pass(b_all_pass),
    .timeout(b_timeout), .cycles(b_cycles)
  );

  test_result_monitor #(.NCH(1), .MODE(0), .HOLD(1), .TIMEOUT(20), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .en(c_en), .pc(c_pc), .gp(c_gp), .st_valid(c_sv),
    .st_addr(c_sa), .st_data(c_sd), .ch_done(c_ch_done), .ch_pass(c_ch_pass),
    .ch_testnum(c_ch_testnum), .all_done(c_all_done), .all_pass(c_all_pass),
    .timeout(c_timeout), .cycles(c_cycles)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (a_ch_done !== 2'b00) begin bad++; $display("FAIL reset_a_done got=%b exp=00", a_ch_done); end
    total++; if (a_ch_testnum !== 16'h0) begin bad++; $display("FAIL reset_a_testnum got=%h exp=0000", a_ch_testnum); end
    total++; if ({a_all_done, a_all_pass, a_timeout} !== 3'b000) begin bad++; $display("FAIL reset_a_status got=%b exp=000", {a_all_done, a_all_pass, a_timeout}); end
    total++; if (a_cycles !== 16'd0) begin bad++; $display("FAIL reset_a_cycles got=%0d exp=0", a_cycles); end
    total++; if ({b_ch_done, b_ch_pass, b_all_done, b_timeout} !== 4'b0000 || b_cycles !== 16'd0) begin bad++; $display("FAIL reset_b got=%b/%0d exp=0000/0", {b_ch_done, b_ch_pass, b_all_done, b_timeout}, b_cycles); end
    total++; if ({c_ch_done, c_all_done, c_timeout} !== 3'b000 || c_cycles !== 8'd0) begin bad++; $display("FAIL reset_c got=%b/%0d exp=000/0", {c_ch_done, c_all_done, c_timeout}, c_cycles); end
  endtask

  task automatic test_pc_pass();
    do_reset();
    a_en = 1'b1;
    a_gp = {32'h1, 32'h1};
    a_pc = {32'h40, 32'h40};
    step();
    a_pc = {32'h44, 32'h44};
    step();
    total++; if (a_ch_done !== 2'b00) begin bad++; $display("FAIL pass_hold1 got=%b exp=00", a_ch_done); end
    step();
    total++; if (a_ch_done !== 2'b11 || a_ch_pass !== 2'b11) begin bad++; $display("FAIL pass_done got=%b/%b exp=11/11", a_ch_done, a_ch_pass); end
    total++; if (a_ch_testnum !== 16'h0 || a_all_done !== 1'b0) begin bad++; $display("FAIL pass_lag got=%h/%b exp=0000/0", a_ch_testnum, a_all_done); end
    a_pc = {32'h80, 32'h80};
    a_gp = {32'h5, 32'h5};
    step();
    total++; if (a_all_done !== 1'b1 || a_all_pass !== 1'b1) begin bad++; $display("FAIL pass_all got=%b/%b exp=1/1", a_all_done, a_all_pass); end
    total++; if (a_ch_pass !== 2'b11 || a_ch_testnum !== 16'h0) begin bad++; $display("FAIL pass_sticky got=%b/%h exp=11/0000", a_ch_pass, a_ch_testnum); end
    a_en = 1'b0;
  endtask

  task automatic test_pc_fail();
    do_reset();
    a_en = 1'b1;
    a_gp = {32'h2A5, 32'h7};
    a_pc = {32'h100, 32'h44};
    step();
    a_pc = {32'h100, 32'h48};
    step();
    total++; if (a_ch_done !== 2'b00) begin bad++; $display("FAIL fail_break got=%b exp=00", a_ch_done); end
    a_pc = {32'h44, 32'h44};
    step();
    total++; if (a_ch_done !== 2'b00) begin bad++; $display("FAIL fail_rehold got=%b exp=00", a_ch_done); end
    step();
    total++; if (a_ch_done !== 2'b11 || a_ch_pass !== 2'b00) begin bad++; $display("FAIL fail_done got=%b/%b exp=11/00", a_ch_done, a_ch_pass); end
    total++; if (a_ch_testnum !== 16'h5203) begin bad++; $display("FAIL fail_testnum got=%h exp=5203", a_ch_testnum); end
    a_gp = {32'h1, 32'h1};
    step();
    total++; if (a_all_done !== 1'b1 || a_all_pass !== 1'b0 || a_ch_testnum !== 16'h5203) begin bad++; $display("FAIL fail_all got=%b/%b/%h exp=1/0/5203", a_all_done, a_all_pass, a_ch_testnum); end
    a_en = 1'b0;
  endtask

  task automatic test_tohost();
    do_reset();
    b_en = 1'b1;
    b_sv = 1'b1; b_sa = 32'h1000; b_sd = 32'h2;
    step();
    total++; if (b_ch_done !== 1'b0) begin bad++; $display("FAIL tohost_even got=%b exp=0", b_ch_done); end
    b_sa = 32'h1004; b_sd = 32'h1;
    step();
    total++; if (b_ch_done !== 1'b0) begin bad++; $display("FAIL tohost_addr got=%b exp=0", b_ch_done); end
    b_sv = 1'b0; b_sa = 32'h1000;
    step();
    total++; if (b_ch_done !== 1'b0) begin bad++; $display("FAIL tohost_novalid got=%b exp=0", b_ch_done); end
    b_sv = 1'b1; b_sd = 32'hB;
    step();
    total++; if (b_ch_done !== 1'b1 || b_ch_pass !== 1'b0 || b_ch_testnum !== 8'd5) begin bad++; $display("FAIL tohost_fail got=%b/%b/%0d exp=1/0/5", b_ch_done, b_ch_pass, b_ch_testnum); end
    b_sd = 32'h1;
    step();
    total++; if (b_ch_pass !== 1'b0 || b_ch_testnum !== 8'd5 || b_all_done !== 1'b1 || b_all_pass !== 1'b0) begin bad++; $display("FAIL tohost_sticky got=%b/%0d/%b/%b exp=0/5/1/0", b_ch_pass, b_ch_testnum, b_all_done, b_all_pass); end
    do_reset();
    b_sv = 1'b1; b_sa = 32'h1000; b_sd = 32'h1;
    step();
    total++; if (b_ch_done !== 1'b1 || b_ch_pass !== 1'b1 || b_ch_testnum !== 8'd0) begin bad++; $display("FAIL tohost_pass got=%b/%b/%0d exp=1/1/0", b_ch_done, b_ch_pass, b_ch_testnum); end
    b_sv = 1'b0;
    step();
    total++; if (b_all_pass !== 1'b1) begin bad++; $display("FAIL tohost_allpass got=%b exp=1", b_all_pass); end
    b_en = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    c_en = 1'b1; c_pc = 32'h0; c_gp = 32'h0;
    repeat (19) step();
    total++; if (c_timeout !== 1'b0 || c_cycles !== 8'd19 || c_all_done !== 1'b0) begin bad++; $display("FAIL wd_before got=%b/%0d/%b exp=0/19/0", c_timeout, c_cycles, c_all_done); end
    step();
    total++; if (c_timeout !== 1'b1 || c_all_done !== 1'b1 || c_all_pass !== 1'b0 || c_ch_done !== 1'b0) begin bad++; $display("FAIL wd_fire got=%b/%b/%b/%b exp=1/1/0/0", c_timeout, c_all_done, c_all_pass, c_ch_done); end
    c_pc = 32'h44; c_gp = 32'h1;
    step();
    total++; if (c_ch_done !== 1'b0 || c_timeout !== 1'b1 || c_cycles !== 8'd21) begin bad++; $display("FAIL wd_frozen got=%b/%b/%0d exp=0/1/21", c_ch_done, c_timeout, c_cycles); end
    c_en = 1'b0;
  endtask

  task automatic test_en_gap();
    do_reset();
    c_en = 1'b1; c_pc = 32'h0;
    repeat (10) step();
    c_en = 1'b0;
    repeat (5) step();
    total++; if (c_cycles !== 8'd10) begin bad++; $display("FAIL gap_hold got=%0d exp=10", c_cycles); end
    c_en = 1'b1;
    repeat (9) step();
    total++; if (c_timeout !== 1'b0 || c_cycles !== 8'd19) begin bad++; $display("FAIL gap_before got=%b/%0d exp=0/19", c_timeout, c_cycles); end
    step();
    total++; if (c_timeout !== 1'b1) begin bad++; $display("FAIL gap_fire got=%b exp=1", c_timeout); end
    c_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    c_en = 1'b1; c_pc = 32'h0; c_gp = 32'h1;
    repeat (19) step();
    c_pc = 32'h44;
    step();
    total++; if (c_ch_done !== 1'b1 || c_ch_pass !== 1'b1 || c_timeout !== 1'b0) begin bad++; $display("FAIL simul_edge got=%b/%b/%b exp=1/1/0", c_ch_done, c_ch_pass, c_timeout); end
    c_pc = 32'h0;
    step();
    total++; if (c_all_done !== 1'b1 || c_all_pass !== 1'b1 || c_timeout !== 1'b0) begin bad++; $display("FAIL simul_all got=%b/%b/%b exp=1/1/0", c_all_done, c_all_pass, c_timeout); end
    c_en = 1'b0;
  endtask

  task automatic test_two_channel();
    logic [1:0] exp_done;
    logic       exp_all;
    do_reset();
    a_en = 1'b1;
    a_gp = {32'h1, 32'h1};
    for (int k = 1; k <= 17; k++) begin
      a_pc[31:0]  = (k == 9  || k == 10) ? 32'h44 : 32'h40;
      a_pc[63:32] = (k == 14 || k == 15) ? 32'h44 : 32'h40;
      step();
      exp_done = {1'(k >= 15), 1'(k >= 10)};
      exp_all  = (k >= 16);
      total++; if (a_ch_done !== exp_done) begin bad++; $display("FAIL two_done k=%0d got=%b exp=%b", k, a_ch_done, exp_done); end
      total++; if (a_all_done !== exp_all || a_all_pass !== exp_all) begin bad++; $display("FAIL two_all k=%0d got=%b/%b exp=%b", k, a_all_done, a_all_pass, exp_all); end
      total++; if (a_cycles !== 16'(k)) begin bad++; $display("FAIL two_cycles k=%0d got=%0d exp=%0d", k, a_cycles, k); end
    end
    a_en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    a_en = 1'b1;
    a_pc = {32'h44, 32'h44};
    a_gp = {32'h1, 32'h1};
    step();
    #2 rst = 1'b0;
    #1;
    total++; if (a_ch_done !== 2'b00 || a_cycles !== 16'd0) begin bad++; $display("FAIL arst_hold got=%b/%0d exp=00/0", a_ch_done, a_cycles); end
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    total++; if (a_ch_done !== 2'b00) begin bad++; $display("FAIL arst_restart got=%b exp=00", a_ch_done); end
    step();
    total++; if (a_ch_done !== 2'b11) begin bad++; $display("FAIL arst_redone got=%b exp=11", a_ch_done); end
    step();
    total++; if (a_all_pass !== 1'b1) begin bad++; $display("FAIL arst_allpass got=%b exp=1", a_all_pass); end
    #2 rst = 1'b0;
    #1;
    total++; if ({a_ch_done, a_ch_pass, a_all_done, a_all_pass, a_timeout} !== 7'b0 || a_cycles !== 16'd0 || a_ch_testnum !== 16'h0) begin bad++; $display("FAIL arst_done got=%b/%0d exp=0000000/0", {a_ch_done, a_ch_pass, a_all_done, a_all_pass, a_timeout}, a_cycles); end
    @(posedge clk);
    #1 rst = 1'b1;
    a_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pc_pass();
    test_pc_fail();
    test_tohost();
    test_timeout();
    test_en_gap();
    test_simultaneous();
    test_two_channel();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_watchdog got=stuck exp=finish");
    $fatal(1);
  end

endmodule
